iob_fifo2stream: RTL and testbench

- Reader end of the synchronous FIFO: drains a FIFO read port (r_en / r_data / r_empty, read data 1 cycle after r_en) and presents the words as a valid/ready stream.
- Provides first-word-fall-through and full throughput (1 word/cycle) under backpressure, using a 2-entry output skid buffer.
- Sits between iob_fifo_sync's read port and any streaming consumer (DMA, serialiser, core input).

---
 rtl/iob_fifo2stream.sv | 122 ++++++++++++
 tb/tb_iob_fifo2stream.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo2stream.sv
// ---------------------------------------------------------------------------
// iob_fifo2stream
//
// Reader end of a synchronous FIFO. Drains the FIFO read port (read data
// arrives one cycle after fifo_r_en) and presents the words as a valid/ready
// stream. A 2-entry skid buffer (head = m_data register, plus tail) gives
// first-word-fall-through behaviour and one word per cycle under
// backpressure, with no combinational path from fifo_r_data to the stream.
//
// Stream handshake: a word transfers on every rising clk edge where
// m_valid & m_ready are both high. Once m_valid is raised it stays high, and
// m_data (and m_last) stay unchanged, until that transfer happens; m_ready
// may change freely.
//
// Parameters:
//   DATA_W  width of FIFO read data and stream data
//   LEN_W   width of the delivered-word counter (and packet length)
//
// Ports:
//   clk          clock
//   arst         asynchronous active-high reset
//   en           allows new FIFO reads to be issued
//   fifo_r_en    FIFO read enable (combinational)
//   fifo_r_data  FIFO read data, valid the cycle after fifo_r_en
//   fifo_empty   FIFO empty flag (registered in the FIFO)
//   m_valid      stream word valid (registered)
//   m_data       stream word (registered)
//   m_ready      consumer accepts word
//   count        words delivered since reset, wraps modulo 2^LEN_W
//
// Optional feature, enabled by defining IOB_FIFO2STREAM_LAST_EN:
//   len          packet length in words (0 is treated as 1)
//   m_last       marks the final word of each packet
// ---------------------------------------------------------------------------
module iob_fifo2stream #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_r_data,
  input  logic              fifo_empty,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
`ifdef IOB_FIFO2STREAM_LAST_EN
  input  logic [LEN_W-1:0]  len,
  output logic              m_last,
`endif
  output logic [LEN_W-1:0]  count
);

  logic [1:0]        occ;       // buffered words (head, then tail)
  logic              inflight;  // a read was issued last cycle
  logic [DATA_W-1:0] tail;
  logic              pop;
  logic [2:0]        level;     // words owned after this cycle's pop
  logic [1:0]        occ_kept;  // buffered words left after the pop
  logic [1:0]        occ_nxt;

  assign pop      = m_valid & m_ready;
  assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign occ_kept = occ - {1'b0, pop};
  assign occ_nxt  = occ_kept + {1'b0, inflight};

  // A read is only issued when the word it returns is guaranteed a slot,
  // so occ + inflight never exceeds 2. Gating with arst keeps the read
  // enable low for the whole time reset is asserted.
  assign fifo_r_en = ~arst & en & ~fifo_empty & (level < 3'd2);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= fifo_r_en;
      occ      <= occ_nxt;
      m_valid  <= (occ_nxt != 2'd0);
      count    <= count + {{(LEN_W-1){1'b0}}, pop};

      // Popping a full buffer promotes tail into head.
      if (pop && (occ == 2'd2)) begin
        m_data <= tail;
      end

      // Returning read data goes to head when head is free after the pop,
      // otherwise behind it in tail. Capture at occ_kept==0 and the
      // promotion above are mutually exclusive.
      if (inflight) begin
        if (occ_kept == 2'd0) begin
          m_data <= fifo_r_data;
        end else begin
          tail <= fifo_r_data;
        end
      end
    end
  end

`ifdef IOB_FIFO2STREAM_LAST_EN
  logic [LEN_W-1:0] pkt_cnt;  // index of head word within its packet
  logic [LEN_W-1:0] len_m1;

  // len == 0 behaves like len == 1: every word closes a packet.
  assign len_m1 = (len == '0) ? '0 : len - 1'b1;
  assign m_last = m_valid & (pkt_cnt == len_m1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      pkt_cnt <= m_last ? '0 : pkt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_fifo2stream.sv
// ---------------------------------------------------------------------------
// tb_iob_fifo2stream
//
// Bench for iob_fifo2stream. A behavioural FIFO (memory + pointers, empty
// flag registered) feeds the DUT. Every pushed word is also appended to
// exp_q; the stream must reproduce exp_q in order. Per-cycle invariants
// (no read from an empty FIFO, no read while disabled, at most 2 words owned,
// hold rule, count equal to words delivered modulo 2^LEN_W) are checked in
// tick(). Scenario tasks add their own timing and content checks.
// Define IOB_FIFO2STREAM_LAST_EN to also exercise len / m_last.
// ---------------------------------------------------------------------------
module tb_iob_fifo2stream;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;   // small so the counter wraps during the run
  localparam int DEPTH  = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst    = 1'b1;
  logic              en      = 1'b0;
  logic              m_ready = 1'b0;
  logic              fifo_r_en;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_r_data = '0;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [LEN_W-1:0]  count;
`ifdef IOB_FIFO2STREAM_LAST_EN
  logic [LEN_W-1:0]  len = '0;
  logic              m_last;
`endif

  iob_fifo2stream #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .arst        (arst),
    .en          (en),
    .fifo_r_en   (fifo_r_en),
    .fifo_r_data (fifo_r_data),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
`ifdef IOB_FIFO2STREAM_LAST_EN
    .len         (len),
    .m_last      (m_last),
`endif
    .count       (count)
  );

  // ---------------- behavioural FIFO ----------------
  // Written by push_word() (mem, wr_ptr); read side owned by this block.
  // While arst is high the model flushes itself so the DUT restarts empty.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [9:0]        wr_ptr = '0;
  logic [9:0]        rd_ptr = '0;

  always @(posedge clk) begin
    if (arst) begin
      rd_ptr     <= wr_ptr;
      fifo_empty <= 1'b1;
    end else if (fifo_r_en) begin
      fifo_r_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 10'd1;
      fifo_empty  <= (wr_ptr == rd_ptr + 10'd1);
    end else begin
      fifo_empty  <= (wr_ptr == rd_ptr);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int tests_run = 0;
  int failures  = 0;
  int exp_idx   = 0;   // next exp_q entry the stream must deliver
  int rd_cnt    = 0;   // reads issued since reset
  int pop_cnt   = 0;   // words delivered since reset
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;

  // Per-cycle samples for the scenario tasks.
  logic              s_valid, s_ready, s_rd, s_hs, s_last;
  logic [DATA_W-1:0] s_data;

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DATA_W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 10'd1;
    exp_q.push_back(v);
  endtask

  // One clock cycle: sample and check at the falling edge, then return
  // 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    bit exp_last;
    int eff_len;
    @(negedge clk);
    s_valid = m_valid;
    s_ready = m_ready;
    s_data  = m_data;
    s_rd    = fifo_r_en;
    s_hs    = m_valid & m_ready;
    s_last  = 1'b0;
    exp_last = 1'b0;
    eff_len  = 1;
`ifdef IOB_FIFO2STREAM_LAST_EN
    s_last = m_last;
`endif
    if (arst) begin
      exp_idx    = exp_q.size();
      rd_cnt     = 0;
      pop_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      tests_run++;
      if ((fifo_r_en & fifo_empty) !== 1'b0) begin
        failures++;
        $display("FAIL rd_while_empty: fifo_r_en=%b fifo_empty=%b, required no read", fifo_r_en, fifo_empty);
      end
      tests_run++;
      if ((fifo_r_en & ~en) !== 1'b0) begin
        failures++;
        $display("FAIL rd_while_disabled: fifo_r_en=%b en=%b, required no read", fifo_r_en, en);
      end
      tests_run++;
      if (rd_cnt - pop_cnt > 2) begin
        failures++;
        $display("FAIL read_ahead: %0d words owned, required at most 2", rd_cnt - pop_cnt);
      end
      tests_run++;
      if (count !== LEN_W'(pop_cnt)) begin
        failures++;
        $display("FAIL count: got %0d, expected %0d", count, LEN_W'(pop_cnt));
      end
      if (prev_stall) begin
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          failures++;
          $display("FAIL hold: m_valid=%b m_data=%h, expected 1 / %h", m_valid, m_data, prev_data);
        end
      end
`ifdef IOB_FIFO2STREAM_LAST_EN
      eff_len  = (len == '0) ? 1 : int'(len);
      exp_last = m_valid && ((pop_cnt % eff_len) == eff_len - 1);
      tests_run++;
      if (m_last !== exp_last) begin
        failures++;
        $display("FAIL m_last: got %b, expected %b (word %0d, len %0d)", m_last, exp_last, pop_cnt + 1, len);
      end
      if (prev_stall) begin
        tests_run++;
        if (m_last !== prev_last) begin
          failures++;
          $display("FAIL hold_last: got %b, expected %b", m_last, prev_last);
        end
      end
`endif
      if (s_hs) begin
        tests_run++;
        if (exp_idx >= exp_q.size()) begin
          failures++;
          $display("FAIL extra_word: got %h, expected no word", m_data);
        end else if (m_data !== exp_q[exp_idx]) begin
          failures++;
          $display("FAIL order: word %0d got %h, expected %h", pop_cnt + 1, m_data, exp_q[exp_idx]);
        end
        exp_idx++;
        pop_cnt++;
      end
      if (s_rd) rd_cnt++;
      prev_stall = s_valid & ~s_ready;
      prev_data  = s_data;
      prev_last  = s_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst    = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    arst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (m_valid !== 1'b0 || count !== '0 || fifo_r_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: m_valid=%b count=%0d fifo_r_en=%b, expected 0/0/0", m_valid, count, fifo_r_en);
    end
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
    tick();
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_stall: m_valid=%b, expected 1", m_valid);
    end
    // Assert reset mid-cycle: outputs must clear without a clock edge.
    arst = 1'b1;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || fifo_r_en !== 1'b0 || count !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_async: m_valid=%b fifo_r_en=%b count=%0d m_data=%h, expected all 0", m_valid, fifo_r_en, count, m_data);
    end
    tick();
    tick();
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (s_valid !== 1'b0 || s_rd !== 1'b0 || count !== '0) begin
        failures++;
        $display("FAIL reset_release: m_valid=%b fifo_r_en=%b count=%0d, expected 0/0/0", s_valid, s_rd, count);
      end
    end
  endtask

  task automatic test_throughput();
    int first_rd, first_v, last_beat, beats, rds;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
    tick();
    en = 1'b1;
    m_ready = 1'b1;
    first_rd = -1; first_v = -1; last_beat = -1; beats = 0; rds = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_rd) begin
        rds++;
        if (first_rd < 0) first_rd = c;
      end
      if (s_valid && first_v < 0) first_v = c;
      if (s_hs) begin
        beats++;
        last_beat = c;
      end
    end
    tests_run++;
    if (first_rd < 0 || first_v - first_rd != 2) begin
      failures++;
      $display("FAIL tp_latency: first read cycle %0d, first valid cycle %0d, expected distance 2", first_rd, first_v);
    end
    tests_run++;
    if (beats != 8 || last_beat - first_v != 7) begin
      failures++;
      $display("FAIL tp_beats: %0d beats spanning %0d cycles, expected 8 beats over 8 cycles", beats, last_beat - first_v + 1);
    end
    tests_run++;
    if (rds != 8) begin
      failures++;
      $display("FAIL tp_reads: %0d fifo_r_en pulses, expected 8", rds);
    end
    tests_run++;
    if (count !== LEN_W'(8)) begin
      failures++;
      $display("FAIL tp_count: got %0d, expected 8", count);
    end
  endtask

  task automatic test_backpressure();
    int rds, beats, first_b, last_b;
    logic [DATA_W-1:0] got [8];
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
    tick();
    en = 1'b1;
    m_ready = 1'b0;
    rds = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_rd) rds++;
    end
    tests_run++;
    if (rds != 2) begin
      failures++;
      $display("FAIL bp_reads: %0d fifo_r_en pulses while stalled, expected 2", rds);
    end
    tests_run++;
    if (s_valid !== 1'b1 || s_data !== DATA_W'(1)) begin
      failures++;
      $display("FAIL bp_head: m_valid=%b m_data=%h, expected 1 / 0001", s_valid, s_data);
    end
    m_ready = 1'b1;
    beats = 0; first_b = -1; last_b = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_hs) begin
        if (beats < 8) got[beats] = s_data;
        if (first_b < 0) first_b = c;
        last_b = c;
        beats++;
      end
    end
    tests_run++;
    if (beats != 8 || last_b - first_b != 7) begin
      failures++;
      $display("FAIL bp_drain: %0d beats spanning %0d cycles, expected 8 over 8", beats, last_b - first_b + 1);
    end
    for (int i = 0; i < 8 && i < beats; i++) begin
      tests_run++;
      if (got[i] !== DATA_W'(i + 1)) begin
        failures++;
        $display("FAIL bp_data: beat %0d got %h, expected %h", i, got[i], DATA_W'(i + 1));
      end
    end
  endtask

  task automatic test_en_drop();
    int n, cyc, rd_off, beats_b, beats_c;
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(DATA_W'(16'h0a00 + i));
    tick();
    en = 1'b1;
    m_ready = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 10) begin
      tick();
      if (s_rd) n++;
      cyc++;
    end
    tests_run++;
    if (n != 2) begin
      failures++;
      $display("FAIL en_reads: %0d reads before drop, expected 2", n);
    end
    en = 1'b0;
    rd_off = 0; beats_b = 0; beats_c = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_rd) rd_off++;
    end
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_rd) rd_off++;
      if (s_hs) beats_b++;
    end
    tests_run++;
    if (rd_off != 0 || beats_b != 2) begin
      failures++;
      $display("FAIL en_drop: %0d reads and %0d beats with en=0, expected 0 and 2", rd_off, beats_b);
    end
    en = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (s_hs) beats_c++;
    end
    tests_run++;
    if (beats_c != 4 || count !== LEN_W'(6)) begin
      failures++;
      $display("FAIL en_resume: %0d beats count=%0d, expected 4 beats count=6", beats_c, count);
    end
  endtask

  task automatic test_random();
    int pushed, cyc;
    do_reset();
    pushed = 0; cyc = 0;
    while (pop_cnt < 200 && cyc < 4000) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin
        push_word(DATA_W'($urandom));
        pushed++;
      end
      en      = ($urandom_range(0, 9) < 8);
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    tests_run++;
    if (pop_cnt != 200) begin
      failures++;
      $display("FAIL rand_done: %0d words delivered in %0d cycles, expected 200", pop_cnt, cyc);
    end
    m_ready = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (s_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_dup: m_valid=%b after all words delivered, expected 0", s_valid);
      end
    end
    // 200 deliveries wrap a 4-bit counter to 200 mod 16 = 8.
    tests_run++;
    if (count !== LEN_W'(8)) begin
      failures++;
      $display("FAIL rand_count_wrap: got %0d, expected 8", count);
    end
  endtask

`ifdef IOB_FIFO2STREAM_LAST_EN
  task automatic test_last();
    logic [31:0] last_mask;
    int cyc, n_last;
    do_reset();
    len = LEN_W'(4);
    for (int i = 0; i < 12; i++) push_word(DATA_W'(16'h0100 + i));
    tick();
    en = 1'b1;
    last_mask = '0;
    cyc = 0;
    while (pop_cnt < 12 && cyc < 200) begin
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      if (s_hs && s_last) last_mask[pop_cnt] = 1'b1;
      cyc++;
    end
    tests_run++;
    if (last_mask !== 32'h0000_1110) begin
      failures++;
      $display("FAIL last_len4: last on words mask %h, expected 00001110", last_mask);
    end
    m_ready = 1'b0;
    len = '0;
    for (int i = 0; i < 5; i++) push_word(DATA_W'(16'h0200 + i));
    n_last = 0;
    cyc = 0;
    while (pop_cnt < 17 && cyc < 200) begin
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
      if (s_hs && s_last) n_last++;
      cyc++;
    end
    tests_run++;
    if (n_last != 5) begin
      failures++;
      $display("FAIL last_len0: %0d last words of 5, expected 5", n_last);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_en_drop();
    test_random();
`ifdef IOB_FIFO2STREAM_LAST_EN
    test_last();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
